// File: rtl/calc_pkg.sv
// Shared keypad, operator, display and state definitions for the calculator front end.
package calc_pkg;

  localparam logic [4:0] KEY_NONE = 5'h1F;
  localparam logic [4:0] KEY_ADD  = 5'h10;
  localparam logic [4:0] KEY_SUB  = 5'h11;
  localparam logic [4:0] KEY_MUL  = 5'h12;
  localparam logic [4:0] KEY_DIV  = 5'h13;
  localparam logic [4:0] KEY_MOD  = 5'h14;
  localparam logic [4:0] KEY_EQ   = 5'h15;
  localparam logic [4:0] KEY_SIGN = 5'h16;
  localparam logic [4:0] KEY_CLR  = 5'h17;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4
  } op_t;

  localparam logic [31:0] DISP_ERR = 32'h00EE_0000;
  localparam logic [31:0] DISP_ADD = 32'h0010_0000;
  localparam logic [31:0] DISP_SUB = 32'h0020_0000;
  localparam logic [31:0] DISP_MUL = 32'h0030_0000;
  localparam logic [31:0] DISP_DIV = 32'h0040_0000;
  localparam logic [31:0] DISP_MOD = 32'h0050_0000;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    OP_SHOW = 3'd1,
    ENTER_B = 3'd2,
    CALC    = 3'd3,
    RESULT  = 3'd4,
    ERROR   = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [4:0] k);
    return k <= 5'd9;
  endfunction

  function automatic logic is_op(input logic [4:0] k);
    return (k >= KEY_ADD) && (k <= KEY_MOD);
  endfunction

  function automatic logic [31:0] op_disp(input op_t op);
    case (op)
      OP_ADD:  return DISP_ADD;
      OP_SUB:  return DISP_SUB;
      OP_MUL:  return DISP_MUL;
      OP_DIV:  return DISP_DIV;
      default: return DISP_MOD;
    endcase
  endfunction

  function automatic logic [31:0] signed_val(input logic [31:0] mag, input logic neg);
    return neg ? (32'd0 - mag) : mag;
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Turns the keypad's level-coded eBCD into a single-cycle key event on release-to-press.
module key_event_detect
  import calc_pkg::*;
(
  input  logic       sw_clk,
  input  logic       rst,
  input  logic [4:0] eBCD,
  output logic       key_event,
  output logic [4:0] key_code
);

  logic [4:0] prev_key;

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) prev_key <= KEY_NONE;
    else      prev_key <= eBCD;
  end

  assign key_event = (prev_key == KEY_NONE) && (eBCD != KEY_NONE);
  assign key_code  = eBCD;

endmodule

// File: rtl/key_sequencer.sv
// Keypad entry sequencer: builds signed operands, selects the operator and shows results.
module key_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 6,
  parameter int CALC_WAIT  = 2
) (
  input  logic        sw_clk,
  input  logic        rst,
  input  logic [4:0]  eBCD,
  input  logic [31:0] result,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic [2:0]  operator,
  output logic [31:0] fnd_serial
);

  localparam int NDW = $clog2(MAX_DIGITS + 1);
  localparam int CW  = (CALC_WAIT > 1) ? $clog2(CALC_WAIT) : 1;

  logic       key_event;
  logic [4:0] key_code;

  key_event_detect u_key_event_detect (
    .sw_clk    (sw_clk),
    .rst       (rst),
    .eBCD      (eBCD),
    .key_event (key_event),
    .key_code  (key_code)
  );

  state_t         state, state_n;
  logic [31:0]    buffer, buffer_n;
  logic [NDW-1:0] ndig, ndig_n;
  logic           sign_bit, sign_n;
  logic [31:0]    op1_q, op1_n, op2_q, op2_n, fnd_q, fnd_n;
  op_t            opr_q, opr_n;
  logic [CW-1:0]  cnt, cnt_n;

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      state    <= ENTER_A;
      buffer   <= '0;
      ndig     <= '0;
      sign_bit <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      opr_q    <= OP_ADD;
      fnd_q    <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      buffer   <= buffer_n;
      ndig     <= ndig_n;
      sign_bit <= sign_n;
      op1_q    <= op1_n;
      op2_q    <= op2_n;
      opr_q    <= opr_n;
      fnd_q    <= fnd_n;
      cnt      <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    buffer_n = buffer;
    ndig_n   = ndig;
    sign_n   = sign_bit;
    op1_n    = op1_q;
    op2_n    = op2_q;
    opr_n    = opr_q;
    fnd_n    = fnd_q;
    cnt_n    = cnt;

    if (key_event && key_code == KEY_CLR) begin
      state_n  = ENTER_A;
      buffer_n = '0;
      ndig_n   = '0;
      sign_n   = 1'b0;
      op1_n    = '0;
      op2_n    = '0;
      opr_n    = OP_ADD;
      fnd_n    = '0;
      cnt_n    = '0;
    end else begin
      case (state)
        ENTER_A, ENTER_B: if (key_event) begin
          if (is_digit(key_code)) begin
            // Leading zeros leave buffer at 0 and must not use up digit slots.
            if (!(buffer == '0 && key_code == 5'd0) && ndig < NDW'(MAX_DIGITS)) begin
              buffer_n = buffer * 32'd10 + {27'd0, key_code};
              ndig_n   = ndig + 1'b1;
            end
            fnd_n = signed_val(buffer_n, sign_bit);
          end else if (key_code == KEY_SIGN) begin
            if (buffer <= 32'd99999) sign_n = ~sign_bit;
            fnd_n = signed_val(buffer, sign_n);
          end else if (is_op(key_code) && state == ENTER_A) begin
            op1_n    = signed_val(buffer, sign_bit);
            opr_n    = op_t'(key_code[2:0]);
            buffer_n = '0;
            ndig_n   = '0;
            sign_n   = 1'b0;
            fnd_n    = op_disp(opr_n);
            state_n  = OP_SHOW;
          end else if (key_code == KEY_EQ && state == ENTER_B) begin
            op2_n   = signed_val(buffer, sign_bit);
            cnt_n   = '0;
            state_n = CALC;
          end
        end
        OP_SHOW: if (key_event) begin
          if (is_op(key_code)) begin
            opr_n = op_t'(key_code[2:0]);
            fnd_n = op_disp(opr_n);
          end else if (is_digit(key_code)) begin
            buffer_n = {27'd0, key_code};
            ndig_n   = (key_code != 5'd0) ? NDW'(1) : '0;
            sign_n   = 1'b0;
            fnd_n    = {27'd0, key_code};
            state_n  = ENTER_B;
          end
        end
        CALC: begin
          if (cnt == CW'(CALC_WAIT - 1)) begin
            fnd_n   = result;
            cnt_n   = '0;
            state_n = (result == DISP_ERR) ? ERROR : RESULT;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RESULT: if (key_event) begin
          // fnd_q still holds the captured result while in RESULT.
          if (is_op(key_code)) begin
            op1_n    = fnd_q;
            opr_n    = op_t'(key_code[2:0]);
            buffer_n = '0;
            ndig_n   = '0;
            sign_n   = 1'b0;
            fnd_n    = op_disp(opr_n);
            state_n  = OP_SHOW;
          end else if (is_digit(key_code)) begin
            buffer_n = {27'd0, key_code};
            ndig_n   = (key_code != 5'd0) ? NDW'(1) : '0;
            sign_n   = 1'b0;
            fnd_n    = {27'd0, key_code};
            state_n  = ENTER_A;
          end
        end
        ERROR:   ;
        default: state_n = ENTER_A;
      endcase
    end
  end

  assign operand1   = op1_q;
  assign operand2   = op2_q;
  assign operator   = opr_q;
  assign fnd_serial = fnd_q;

endmodule

// File: tb/tb_key_sequencer.sv
// Self-checking bench for key_sequencer: per-key behavioural model plus directed and random keys.
module tb_key_sequencer;

  localparam int MAXD  = 6;
  localparam int CWAIT = 2;
  localparam int ERRV  = 32'h00EE_0000;

  logic        sw_clk;
  logic        rst;
  logic [4:0]  eBCD;
  logic [31:0] result;
  logic [31:0] operand1, operand2, fnd_serial;
  logic [2:0]  operator;

  key_sequencer #(.MAX_DIGITS(MAXD), .CALC_WAIT(CWAIT)) dut (
    .sw_clk     (sw_clk),
    .rst        (rst),
    .eBCD       (eBCD),
    .result     (result),
    .operand1   (operand1),
    .operand2   (operand2),
    .operator   (operator),
    .fnd_serial (fnd_serial)
  );

  initial sw_clk = 1'b0;
  always #5 sw_clk = ~sw_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  // Behavioural model: modes are just phases of a pocket-calculator session.
  localparam int M_A = 0, M_OP = 1, M_B = 2, M_WAIT = 3, M_RES = 4, M_ERR = 5;
  int   m_mode, m_mag, m_op1, m_op2, m_opr, m_fnd, m_res, m_wait;
  bit   m_neg;
  logic [4:0] m_prev;

  function automatic int calc(input int a, input int b, input int op);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      3: return (b == 0) ? ERRV : a / b;
      default: return (b == 0) ? ERRV : a % b;
    endcase
  endfunction

  function automatic int mval(input int mag, input bit neg);
    return neg ? -mag : mag;
  endfunction

  always @(negedge sw_clk) result = calc(m_op1, m_op2, m_opr);

  always @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      m_mode = M_A; m_mag = 0; m_neg = 0; m_op1 = 0; m_op2 = 0;
      m_opr = 0; m_fnd = 0; m_res = 0; m_wait = 0; m_prev = 5'h1F;
    end else begin
      bit ev;
      int k;
      ev = (m_prev == 5'h1F) && (eBCD != 5'h1F);
      k = int'(eBCD);
      m_prev = eBCD;
      if (ev && k == 'h17) begin
        m_mode = M_A; m_mag = 0; m_neg = 0; m_op1 = 0; m_op2 = 0; m_opr = 0; m_fnd = 0;
      end else if (m_mode == M_WAIT) begin
        m_wait--;
        if (m_wait == 0) begin
          m_res = int'(result);
          m_fnd = m_res;
          m_mode = (m_res == ERRV) ? M_ERR : M_RES;
        end
      end else if (ev) begin
        case (m_mode)
          M_A, M_B: begin
            if (k <= 9) begin
              if (m_mag < 10 ** (MAXD - 1)) m_mag = m_mag * 10 + k;
              m_fnd = mval(m_mag, m_neg);
            end else if (k == 'h16) begin
              if (m_mag <= 99999) m_neg = !m_neg;
              m_fnd = mval(m_mag, m_neg);
            end else if (k >= 'h10 && k <= 'h14 && m_mode == M_A) begin
              m_op1 = mval(m_mag, m_neg); m_opr = k - 'h10;
              m_mag = 0; m_neg = 0; m_fnd = (m_opr + 1) * 'h10_0000; m_mode = M_OP;
            end else if (k == 'h15 && m_mode == M_B) begin
              m_op2 = mval(m_mag, m_neg); m_wait = CWAIT; m_mode = M_WAIT;
            end
          end
          M_OP, M_RES: begin
            if (k >= 'h10 && k <= 'h14) begin
              if (m_mode == M_RES) begin m_op1 = m_res; m_mag = 0; m_neg = 0; end
              m_opr = k - 'h10; m_fnd = (m_opr + 1) * 'h10_0000; m_mode = M_OP;
            end else if (k <= 9) begin
              m_mag = k; m_neg = 0; m_fnd = k;
              m_mode = (m_mode == M_OP) ? M_B : M_A;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge sw_clk) begin
    if (rst) begin
      check("operand1", operand1, 32'(m_op1));
      check("operand2", operand2, 32'(m_op2));
      check("operator", {29'd0, operator}, 32'(m_opr));
      check("fnd_serial", fnd_serial, 32'(m_fnd));
    end
  end

  // Caller is 2 time units after a rising edge; returns at the same phase.
  task automatic press(input logic [4:0] c, input int hold, input int gap);
    eBCD = c;
    repeat (hold) @(posedge sw_clk);
    #2 eBCD = 5'h1F;
    repeat (gap) @(posedge sw_clk);
    if (gap > 0) #2;
  endtask

  task automatic key(input logic [4:0] c);
    press(c, 1, 1);
  endtask

  initial begin
    rst = 1'b0;
    eBCD = 5'h1F;
    #12;
    check("reset_op1", operand1, 32'd0);
    check("reset_fnd", fnd_serial, 32'd0);
    @(posedge sw_clk); #2 rst = 1'b1;
    @(posedge sw_clk); #2;

    key(5'd1); check("d1", fnd_serial, 32'd1);
    key(5'd2); check("d12", fnd_serial, 32'd12);
    key(5'd3); check("d123", fnd_serial, 32'd123);

    key(5'h17);
    key(5'd1); key(5'd0); key(5'h10);
    check("add_op1", operand1, 32'd10);
    check("add_opr", {29'd0, operator}, 32'd0);
    check("add_disp", fnd_serial, 32'h0010_0000);
    key(5'd1); key(5'd0); key(5'd1);
    press(5'h15, 1, 0);
    check("eq_op2", operand2, 32'd101);
    @(posedge sw_clk); #2;
    check("calc_pending", {31'd0, fnd_serial == 32'd111}, 32'd0);
    @(posedge sw_clk); #2;
    check("calc_result", fnd_serial, 32'd111);
    key(5'h12);
    check("chain_op1", operand1, 32'd111);
    check("chain_disp", fnd_serial, 32'h0030_0000);

    key(5'h17);
    for (int d = 1; d <= 7; d++) key(5'(d));
    check("max_digits", fnd_serial, 32'd123456);
    key(5'h16); check("toggle_big", fnd_serial, 32'd123456);
    key(5'h17); key(5'd5); key(5'h16);
    check("toggle_neg", fnd_serial, 32'hFFFF_FFFB);

    key(5'h17);
    key(5'd7); key(5'h13); key(5'd0); key(5'h15);
    repeat (3) @(posedge sw_clk); #2;
    check("err_disp", fnd_serial, 32'h00EE_0000);
    key(5'd3); check("err_ignore", fnd_serial, 32'h00EE_0000);
    key(5'h17); check("err_clear", fnd_serial, 32'd0);
    key(5'd4); check("after_clear", fnd_serial, 32'd4);

    key(5'h17);
    press(5'd3, 10, 1);
    check("held_key", fnd_serial, 32'd3);

    key(5'h17);
    key(5'd2); key(5'h10); key(5'd3); press(5'h15, 1, 0);
    #1 rst = 1'b0;
    #1;
    check("arst_op1", operand1, 32'd0);
    check("arst_op2", operand2, 32'd0);
    check("arst_opr", {29'd0, operator}, 32'd0);
    check("arst_fnd", fnd_serial, 32'd0);
    eBCD = 5'd5;
    @(posedge sw_clk); #2 rst = 1'b1;
    @(posedge sw_clk); #2;
    check("fresh_after_rst", fnd_serial, 32'd5);
    eBCD = 5'h1F;
    @(posedge sw_clk); #2;

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [4:0] c;
      r = $urandom_range(0, 99);
      if (r < 50)      c = 5'($urandom_range(0, 9));
      else if (r < 68) c = 5'($urandom_range(16, 20));
      else if (r < 80) c = 5'h15;
      else if (r < 87) c = 5'h16;
      else if (r < 93) c = 5'h17;
      else             c = 5'($urandom_range(24, 30));
      press(c, $urandom_range(1, 3), $urandom_range(1, 3));
    end

    @(posedge sw_clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
